// File: rtl/ins_loader_if.sv
// Loader-side bus: host load control, byte stream handshake and instruction-memory mux port.
// The master drives the request and byte stream; the slave is the loader itself.
interface ins_loader_if #(
    parameter int unsigned LEN_W = 16
) ();
    logic             load_start;
    logic [LEN_W-1:0] load_len;
    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic             rx_ready;
    logic [31:0]      ins_addr_nap;
    logic [31:0]      ins_data_nap;
    logic             we_cpu;
    logic             sel;
    logic             busy;
    logic             load_done;

    modport master (
        output load_start, load_len, rx_valid, rx_byte,
        input  rx_ready, ins_addr_nap, ins_data_nap, we_cpu, sel, busy, load_done
    );

    modport slave (
        input  load_start, load_len, rx_valid, rx_byte,
        output rx_ready, ins_addr_nap, ins_data_nap, we_cpu, sel, busy, load_done
    );
endinterface

// File: rtl/ins_loader.sv
// Program loader: assembles little-endian byte stream into 32-bit words and writes them
// into instruction memory through the mux, then hands memory ownership to the core.
module ins_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LEN_W     = 16
) (
    input logic        clk,
    input logic        rst,
    ins_loader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] words_left;
    logic [1:0]       byte_cnt;
    logic             start_c;
    logic             take_c;
    logic             wr_exit_c;

    // Next state and datapath strobes; load_start is only honoured when not busy
    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        take_c    = 1'b0;
        wr_exit_c = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.load_start) begin
                    start_c   = 1'b1;
                    state_nxt = (bus.load_len != '0) ? COLLECT : DONE;
                end
            end
            COLLECT: begin
                if (bus.rx_valid && bus.rx_ready) begin
                    take_c = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                wr_exit_c = 1'b1;
                state_nxt = (words_left == LEN_W'(1)) ? DONE : COLLECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Status outputs registered from the next state so they line up with the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rx_ready  <= 1'b0;
            bus.we_cpu    <= 1'b0;
            bus.sel       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.load_done <= 1'b0;
        end else begin
            bus.rx_ready  <= (state_nxt == COLLECT);
            bus.we_cpu    <= (state_nxt == WRITE);
            bus.sel       <= (state_nxt == DONE);
            bus.busy      <= (state_nxt == COLLECT) || (state_nxt == WRITE);
            bus.load_done <= (state_nxt == DONE);
        end
    end

    // Word assembly, address and remaining-word bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_left       <= '0;
            byte_cnt         <= 2'd0;
            bus.ins_addr_nap <= BASE_ADDR;
            bus.ins_data_nap <= 32'd0;
        end else begin
            if (start_c) begin
                words_left       <= bus.load_len;
                byte_cnt         <= 2'd0;
                bus.ins_addr_nap <= BASE_ADDR;
            end
            if (take_c) begin
                bus.ins_data_nap[{byte_cnt, 3'b000} +: 8] <= bus.rx_byte;
                byte_cnt                                  <= byte_cnt + 2'd1;
            end
            if (wr_exit_c) begin
                bus.ins_addr_nap <= bus.ins_addr_nap + 32'd4;
                words_left       <= words_left - LEN_W'(1);
            end
        end
    end
endmodule
